peak_find: RTL and testbench



---
 rtl/peak_find.sv | 113 +++++++++++
 tb/tb_peak_find.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/peak_find.sv
// Per-frame peak detector: tracks the brightest pixel of each frame and its (X, Y).
// The result is reported once, at frame end, with a one-cycle PeakValid pulse.
module peak_find #(
    parameter int XW = 8,
    parameter int YW = 8
) (
    input  logic          Clk,
    input  logic          nReset,
    input  logic [7:0]    PixelIn,
    input  logic          FrameIn,
    input  logic          LineIn,
    input  logic [7:0]    Threshold,
    output logic [7:0]    PeakValue,
    output logic [XW-1:0] PeakX,
    output logic [YW-1:0] PeakY,
    output logic          PeakFound,
    output logic          PeakValid
);

    localparam logic [XW-1:0] X_MAX = '1;
    localparam logic [YW-1:0] Y_MAX = '1;

    logic          frame_d;
    logic          line_d;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          armed;
    logic          first;
    logic [7:0]    max_val;
    logic [XW-1:0] max_x;
    logic [YW-1:0] max_y;

    logic pix_valid;
    logic frame_rise;
    logic frame_fall;
    logic line_fall;
    logic report;
    logic trk_armed;
    logic trk_first;
    logic take_pixel;

    always_comb begin
        pix_valid  = FrameIn & LineIn;
        frame_rise = ~frame_d & FrameIn;
        frame_fall = frame_d & ~FrameIn;
        line_fall  = line_d & ~LineIn;
        report     = frame_fall & armed;
        // A pixel arriving in the same cycle as the frame rise belongs to the new frame.
        trk_armed  = armed | frame_rise;
        trk_first  = first | frame_rise;
        take_pixel = pix_valid & trk_armed & (trk_first | (PixelIn > max_val));
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            // Edge history starts high so a frame already running is not seen as new.
            frame_d   <= 1'b1;
            line_d    <= 1'b1;
            x_cnt     <= '0;
            y_cnt     <= '0;
            armed     <= 1'b0;
            first     <= 1'b0;
            max_val   <= '0;
            max_x     <= '0;
            max_y     <= '0;
            PeakValue <= '0;
            PeakX     <= '0;
            PeakY     <= '0;
            PeakFound <= 1'b0;
            PeakValid <= 1'b0;
        end else begin
            frame_d <= FrameIn;
            line_d  <= LineIn;

            if (!LineIn)
                x_cnt <= '0;
            else if (pix_valid && x_cnt != X_MAX)
                x_cnt <= x_cnt + XW'(1);

            if (!FrameIn)
                y_cnt <= '0;
            else if (line_fall && y_cnt != Y_MAX)
                y_cnt <= y_cnt + YW'(1);

            // Clearing the running max at frame start makes an empty frame report zeros.
            if (frame_rise) begin
                armed   <= 1'b1;
                first   <= 1'b1;
                max_val <= '0;
                max_x   <= '0;
                max_y   <= '0;
            end else if (report) begin
                armed <= 1'b0;
            end

            if (take_pixel) begin
                max_val <= PixelIn;
                max_x   <= x_cnt;
                max_y   <= y_cnt;
                first   <= 1'b0;
            end

            PeakValid <= report;
            if (report) begin
                PeakValue <= max_val;
                PeakX     <= max_x;
                PeakY     <= max_y;
                PeakFound <= ~first & (max_val >= Threshold);
            end
        end
    end

endmodule

// File: tb/tb_peak_find.sv
// Directed bench for peak_find: a default-width instance plus an XW=2 instance
// sharing the same stimulus, used for the X saturation case.
module tb_peak_find;

    logic       Clk;
    logic       nReset;
    logic [7:0] PixelIn;
    logic       FrameIn;
    logic       LineIn;
    logic [7:0] Threshold;

    logic [7:0] PeakValue, sat_value;
    logic [7:0] PeakX;
    logic [1:0] sat_x;
    logic [7:0] PeakY, sat_y;
    logic       PeakFound, sat_found;
    logic       PeakValid, sat_valid;

    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    int exp_pulses = 0;

    logic [7:0] img [0:3][0:5];

    peak_find #(.XW(8), .YW(8)) u_dut (
        .Clk(Clk), .nReset(nReset), .PixelIn(PixelIn), .FrameIn(FrameIn),
        .LineIn(LineIn), .Threshold(Threshold), .PeakValue(PeakValue),
        .PeakX(PeakX), .PeakY(PeakY), .PeakFound(PeakFound), .PeakValid(PeakValid)
    );

    peak_find #(.XW(2), .YW(8)) u_sat (
        .Clk(Clk), .nReset(nReset), .PixelIn(PixelIn), .FrameIn(FrameIn),
        .LineIn(LineIn), .Threshold(Threshold), .PeakValue(sat_value),
        .PeakX(sat_x), .PeakY(sat_y), .PeakFound(sat_found), .PeakValid(sat_valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) if (PeakValid === 1'b1) valid_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rep(input string tag, input logic [7:0] v, input logic [7:0] x,
                             input logic [7:0] y, input logic f);
        check({tag, "_value"}, {24'd0, PeakValue}, {24'd0, v});
        check({tag, "_x"},     {24'd0, PeakX},     {24'd0, x});
        check({tag, "_y"},     {24'd0, PeakY},     {24'd0, y});
        check({tag, "_found"}, {31'd0, PeakFound}, {31'd0, f});
    endtask

    task automatic step(input logic [7:0] p, input logic f, input logic l);
        PixelIn = p;
        FrameIn = f;
        LineIn  = l;
        @(posedge Clk);
        #1;
    endtask

    task automatic fill_img(input logic [7:0] v);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 6; x++)
                img[y][x] = v;
    endtask

    // Rise cycle, nl lines of np pixels each followed by a one-cycle gap, then the fall cycle.
    // Returns in the cycle where the report pulse is expected.
    task automatic run_frame(input int nl, input int np);
        step(8'h00, 1'b1, 1'b0);
        for (int y = 0; y < nl; y++) begin
            for (int x = 0; x < np; x++)
                step(img[y][x], 1'b1, 1'b1);
            step(8'h00, 1'b1, 1'b0);
        end
        step(8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        nReset = 1'b0;
        PixelIn = '0;
        FrameIn = 1'b0;
        LineIn = 1'b0;
        Threshold = '0;
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        check_rep("reset", 8'h00, 8'h00, 8'h00, 1'b0);
        check("reset_valid", {31'd0, PeakValid}, 32'd0);
        nReset = 1'b1;
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);

        // Single peak
        Threshold = 8'h80;
        fill_img(8'h10);
        img[2][3] = 8'hC8;
        run_frame(4, 6);
        exp_pulses++;
        check("t1_pulse", {31'd0, PeakValid}, 32'd1);
        check_rep("t1", 8'hC8, 8'd3, 8'd2, 1'b1);
        step(8'h00, 1'b0, 1'b0);
        check("t1_pulse_end", {31'd0, PeakValid}, 32'd0);
        check_rep("t1_hold", 8'hC8, 8'd3, 8'd2, 1'b1);

        // Tie: earliest wins, below threshold
        Threshold = 8'h60;
        fill_img(8'h00);
        img[0][1] = 8'h50;
        img[3][4] = 8'h50;
        run_frame(4, 6);
        exp_pulses++;
        check("t2_pulse", {31'd0, PeakValid}, 32'd1);
        check_rep("t2", 8'h50, 8'd1, 8'd0, 1'b0);
        step(8'h00, 1'b0, 1'b0);

        // Empty frame
        Threshold = 8'h00;
        repeat (10) step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        exp_pulses++;
        check("t3_pulse", {31'd0, PeakValid}, 32'd1);
        check_rep("t3", 8'h00, 8'd0, 8'd0, 1'b0);
        step(8'h00, 1'b0, 1'b0);

        // Reset released inside a frame: that frame is not reported
        Threshold = 8'h01;
        nReset = 1'b0;
        step(8'h77, 1'b1, 1'b1);
        step(8'h77, 1'b1, 1'b1);
        nReset = 1'b1;
        repeat (3) step(8'hEE, 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        check("t4_no_pulse", valid_cnt, exp_pulses);
        check_rep("t4_cleared", 8'h00, 8'd0, 8'd0, 1'b0);
        fill_img(8'h00);
        img[0][0] = 8'hFF;
        run_frame(4, 6);
        exp_pulses++;
        check("t4_pulse", {31'd0, PeakValid}, 32'd1);
        check_rep("t4", 8'hFF, 8'd0, 8'd0, 1'b1);
        step(8'h00, 1'b0, 1'b0);

        // Back-to-back frames with a single low cycle between them
        Threshold = 8'h20;
        fill_img(8'h00);
        img[1][2] = 8'h40;
        run_frame(4, 6);
        exp_pulses++;
        check("t5a_pulse", {31'd0, PeakValid}, 32'd1);
        check_rep("t5a", 8'h40, 8'd2, 8'd1, 1'b1);
        fill_img(8'h00);
        img[0][5] = 8'h30;
        run_frame(4, 6);
        exp_pulses++;
        check("t5b_pulse", {31'd0, PeakValid}, 32'd1);
        check_rep("t5b", 8'h30, 8'd5, 8'd0, 1'b1);
        step(8'h00, 1'b0, 1'b0);
        check("t5_pulse_count", valid_cnt, exp_pulses);

        // X saturation on the XW=2 instance
        Threshold = 8'h80;
        fill_img(8'h00);
        img[0][5] = 8'h99;
        run_frame(1, 6);
        exp_pulses++;
        check("t6_sat_pulse", {31'd0, sat_valid}, 32'd1);
        check("t6_sat_x", {30'd0, sat_x}, 32'd3);
        check("t6_sat_value", {24'd0, sat_value}, 32'h99);
        check("t6_sat_found", {31'd0, sat_found}, 32'd1);
        check_rep("t6_wide", 8'h99, 8'd5, 8'd0, 1'b1);
        step(8'h00, 1'b0, 1'b0);

        // Reset in the middle of the same frame: never reported
        step(8'h00, 1'b1, 1'b0);
        step(8'h11, 1'b1, 1'b1);
        step(8'h99, 1'b1, 1'b1);
        nReset = 1'b0;
        #1;
        check_rep("t7_reset", 8'h00, 8'd0, 8'd0, 1'b0);
        check("t7_sat_value", {24'd0, sat_value}, 32'd0);
        check("t7_sat_x", {30'd0, sat_x}, 32'd0);
        step(8'h99, 1'b1, 1'b1);
        nReset = 1'b1;
        step(8'hAA, 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        check("t7_no_pulse", valid_cnt, exp_pulses);
        check_rep("t7_hold", 8'h00, 8'd0, 8'd0, 1'b0);
        check("t7_sat_valid", {31'd0, sat_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
